// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous double buffering
// Optional leading-zero anode suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    output logic [3:0]              seg_code,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t                  state, nxt_state;
    logic [IW-1:0]           idx, nxt_idx;
    logic [CW-1:0]           cnt, nxt_cnt;
    logic [4*NUM_DIGITS-1:0] act_digits, pend_digits, src_digits, nxt_act_digits;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp, src_dp, nxt_act_dp;
    logic [NUM_DIGITS-1:0]   act_en, pend_en, src_en_raw, src_en, nxt_act_en;
    logic                    pend_valid, wrap, commit, bypass;
    logic [NUM_DIGITS-1:0]   nxt_an;
    logic [3:0]              nxt_seg;
    logic                    nxt_dp;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic                    higher_blank;
`endif

    // Slot/counter advance; a load on the last cycle of the last slot goes straight to active.
    always_comb begin
        nxt_idx = '0;
        nxt_cnt = '0;
        wrap    = 1'b0;
        commit  = 1'b0;
        bypass  = 1'b0;
        if (enable) begin
            if (state == ST_IDLE) begin
                commit = pend_valid;
            end else if (cnt == CNT_LAST) begin
                if (idx == IDX_LAST) begin
                    wrap   = 1'b1;
                    bypass = load;
                    commit = pend_valid | load;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end else begin
                nxt_idx = idx;
                nxt_cnt = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        src_digits = bypass ? digits_in   : pend_digits;
        src_dp     = bypass ? dp_in       : pend_dp;
        src_en_raw = bypass ? digit_en_in : pend_en;
        src_en     = src_en_raw;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        // Walk down from the most significant digit; zeros stay dark until a shown non-zero digit.
        higher_blank = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (higher_blank && src_digits[4*i +: 4] == 4'h0)
                src_en[i] = 1'b0;
            if (src_en_raw[i] && src_digits[4*i +: 4] != 4'h0)
                higher_blank = 1'b0;
        end
`endif
    end

    always_comb begin
        nxt_act_digits = commit ? src_digits : act_digits;
        nxt_act_dp     = commit ? src_dp     : act_dp;
        nxt_act_en     = commit ? src_en     : act_en;
        nxt_state      = ST_IDLE;
        nxt_an         = '1;
        nxt_seg        = 4'h0;
        nxt_dp         = 1'b0;
        if (enable) begin
            nxt_state = (int'(nxt_cnt) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;
            nxt_seg   = nxt_act_digits[int'(nxt_idx)*4 +: 4];
            nxt_dp    = nxt_act_dp[nxt_idx];
            if (nxt_state == ST_SHOW && nxt_act_en[nxt_idx])
                nxt_an[nxt_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_valid  <= 1'b0;
            seg_code    <= 4'h0;
            dp_out      <= 1'b0;
            an          <= '1;
            frame_done  <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            act_digits <= nxt_act_digits;
            act_dp     <= nxt_act_dp;
            act_en     <= nxt_act_en;
            if (commit)
                pend_valid <= 1'b0;
            if (load && !bypass) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_en     <= digit_en_in;
                pend_valid  <= 1'b1;
            end
            seg_code   <= nxt_seg;
            dp_out     <= nxt_dp;
            an         <= nxt_an;
            frame_done <= wrap;
        end
    end

endmodule
